// File: rtl/battle_datapath.sv
// Battle datapath: holds both HP registers and the player's move power, computes
// attacker-to-defender damage with an iterative shift-add multiplier and applies it
// to the latched target with saturation at zero.
module battle_datapath #(
    parameter int unsigned P_MAX_HP  = 100,
    parameter int unsigned AI_MAX_HP = 100,
    parameter int unsigned P_ATK     = 50,
    parameter int unsigned P_DEF     = 30,
    parameter int unsigned AI_ATK    = 45,
    parameter int unsigned AI_DEF    = 30,
    parameter int unsigned AI_POWER  = 35
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ld_move,
    input  logic [7:0] move_power,
    input  logic       calc_damage,
    input  logic       active_trainer,
    input  logic       target,
    input  logic       apply_damage,
    output logic [7:0] p_hp,
    output logic [7:0] ai_hp,
    output logic       p_hp_zero,
    output logic       ai_hp_zero,
    output logic [7:0] damage,
    output logic       dmg_valid,
    output logic       busy
);

    localparam logic [7:0] PMaxHp  = 8'(P_MAX_HP);
    localparam logic [7:0] AiMaxHp = 8'(AI_MAX_HP);
    localparam logic [7:0] PAtk    = 8'(P_ATK);
    localparam logic [7:0] PDef    = 8'(P_DEF);
    localparam logic [7:0] AiAtk   = 8'(AI_ATK);
    localparam logic [7:0] AiDef   = 8'(AI_DEF);
    localparam logic [7:0] AiPower = 8'(AI_POWER);

    typedef enum logic [1:0] {StIdle, StMul, StClamp, StReady} state_e;

    state_e      state_q, state_d;
    logic [7:0]  move_q;
    logic [15:0] mcand_q;
    logic [7:0]  pwr_q;
    logic [7:0]  def_q;
    logic        tgt_q;
    logic [15:0] prod_q;
    logic [2:0]  cnt_q;
    logic [7:0]  p_hp_q, ai_hp_q, damage_q;
    logic        dmg_valid_q;

    logic        start_calc, apply_hit;
    logic [11:0] scaled, diff;
    logic [7:0]  clamp_val;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (calc_damage) state_d = StMul;
            StMul:   if (cnt_q == 3'd7) state_d = StClamp;
            StClamp: state_d = StReady;
            StReady: if (apply_damage && (target == tgt_q)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs and datapath strobes
    always_comb begin
        busy       = (state_q == StMul) || (state_q == StClamp);
        start_calc = (state_q == StIdle) && calc_damage;
        apply_hit  = (state_q == StReady) && apply_damage && (target == tgt_q);
    end

    // Damage clamp: (product >> 4) - def, limited to 1..255
    always_comb begin
        scaled = prod_q[15:4];
        diff   = scaled - {4'd0, def_q};
        if (scaled <= {4'd0, def_q}) begin
            clamp_val = 8'd1;
        end else if (diff > 12'd255) begin
            clamp_val = 8'd255;
        end else begin
            clamp_val = diff[7:0];
        end
    end

    // Datapath registers: move, operands, multiplier, damage and HP
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            move_q      <= 8'd0;
            mcand_q     <= 16'd0;
            pwr_q       <= 8'd0;
            def_q       <= 8'd0;
            tgt_q       <= 1'b0;
            prod_q      <= 16'd0;
            cnt_q       <= 3'd0;
            p_hp_q      <= PMaxHp;
            ai_hp_q     <= AiMaxHp;
            damage_q    <= 8'd0;
            dmg_valid_q <= 1'b0;
        end else begin
            if (ld_move) begin
                move_q <= move_power;
            end
            // Operands are snapshotted here so later move loads cannot disturb them.
            if (start_calc) begin
                if (active_trainer) begin
                    mcand_q <= {8'd0, AiAtk};
                    pwr_q   <= AiPower;
                    def_q   <= PDef;
                end else begin
                    mcand_q <= {8'd0, PAtk};
                    pwr_q   <= move_q;
                    def_q   <= AiDef;
                end
                tgt_q  <= target;
                prod_q <= 16'd0;
                cnt_q  <= 3'd0;
            end
            if (state_q == StMul) begin
                if (pwr_q[0]) begin
                    prod_q <= prod_q + mcand_q;
                end
                mcand_q <= {mcand_q[14:0], 1'b0};
                pwr_q   <= {1'b0, pwr_q[7:1]};
                cnt_q   <= cnt_q + 3'd1;
            end
            if (state_q == StClamp) begin
                damage_q    <= clamp_val;
                dmg_valid_q <= 1'b1;
            end
            if (apply_hit) begin
                if (tgt_q) begin
                    ai_hp_q <= (ai_hp_q > damage_q) ? (ai_hp_q - damage_q) : 8'd0;
                end else begin
                    p_hp_q <= (p_hp_q > damage_q) ? (p_hp_q - damage_q) : 8'd0;
                end
                dmg_valid_q <= 1'b0;
            end
        end
    end

    assign p_hp       = p_hp_q;
    assign ai_hp      = ai_hp_q;
    assign p_hp_zero  = (p_hp_q == 8'd0);
    assign ai_hp_zero = (ai_hp_q == 8'd0);
    assign damage     = damage_q;
    assign dmg_valid  = dmg_valid_q;

endmodule

// File: tb/tb_battle_datapath.sv
// Scoreboard bench for battle_datapath: stimulus pushes expected damage and the
// cycle it must appear on; a monitor pops on every rising dmg_valid.
module tb_battle_datapath;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ld_move = 1'b0;
    logic [7:0] move_power = 8'd0;
    logic       calc_damage = 1'b0;
    logic       active_trainer = 1'b0;
    logic       target = 1'b0;
    logic       apply_damage = 1'b0;
    logic [7:0] p_hp, ai_hp, damage;
    logic       p_hp_zero, ai_hp_zero, dmg_valid, busy;

    typedef struct {
        logic [7:0] dmg;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic prev_valid = 1'b0;

    battle_datapath dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ld_move        (ld_move),
        .move_power     (move_power),
        .calc_damage    (calc_damage),
        .active_trainer (active_trainer),
        .target         (target),
        .apply_damage   (apply_damage),
        .p_hp           (p_hp),
        .ai_hp          (ai_hp),
        .p_hp_zero      (p_hp_zero),
        .ai_hp_zero     (ai_hp_zero),
        .damage         (damage),
        .dmg_valid      (dmg_valid),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int actual, input int required);
        n_tests++;
        if (actual != required) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    // Monitor: every rising dmg_valid must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (dmg_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got damage %0d, expected no result", damage);
            end else begin
                e = exp_q.pop_front();
                check("damage", int'(damage), int'(e.dmg));
                check("latency_cycle", cyc, e.cyc);
            end
        end
        prev_valid = dmg_valid;
    end

    task automatic load_move(input logic [7:0] v);
        ld_move    = 1'b1;
        move_power = v;
        @(negedge clk);
        ld_move    = 1'b0;
    endtask

    // Start a calculation; calc stays high until the caller drops it.
    task automatic start(input logic who, input logic tgt, input logic [7:0] exp_dmg);
        exp_t e;
        calc_damage    = 1'b1;
        active_trainer = who;
        target         = tgt;
        e.dmg = exp_dmg;
        e.cyc = cyc + 10;
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(input string name);
        int i;
        for (i = 0; i < 20; i++) begin
            if (dmg_valid) break;
            @(negedge clk);
        end
        if (!dmg_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got dmg_valid 0, expected 1 within 20 cycles", name);
        end
    endtask

    task automatic apply(input logic tgt);
        target       = tgt;
        apply_damage = 1'b1;
        @(negedge clk);
        apply_damage = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("rst_p_hp", p_hp, 100);
        check("rst_ai_hp", ai_hp, 100);
        check("rst_dmg_valid", dmg_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_damage", damage, 0);
        check("rst_zero_flags", {p_hp_zero, ai_hp_zero}, 0);

        // Player attack: 50*40=2000 >>4=125 -30 = 95
        load_move(8'd40);
        start(1'b0, 1'b1, 8'd95);
        @(negedge clk);
        calc_damage = 1'b0;
        check("busy_after_start", busy, 1);
        check("valid_during_mul", dmg_valid, 0);
        wait_valid("player");
        check("busy_in_ready", busy, 0);
        apply(1'b1);
        check("player_hit_ai_hp", ai_hp, 5);
        check("player_hit_valid_clr", dmg_valid, 0);
        check("player_hit_p_hp", p_hp, 100);

        // AI attack with calc held high: 45*35=1575 >>4=98 -30 = 68
        start(1'b1, 1'b0, 8'd68);
        @(negedge clk);
        wait_valid("ai");
        calc_damage = 1'b0;
        apply(1'b0);
        check("ai_hit_p_hp", p_hp, 32);

        // Clamp low: 50*5=250 >>4=15 <= 30 -> 1
        load_move(8'd5);
        start(1'b0, 1'b1, 8'd1);
        @(negedge clk);
        calc_damage = 1'b0;
        wait_valid("clamp_low");
        apply(1'b1);
        check("clamp_low_ai_hp", ai_hp, 4);

        // Clamp high, with move loads at the start edge and mid-MUL ignored
        load_move(8'd255);
        start(1'b0, 1'b1, 8'd255);
        ld_move    = 1'b1;
        move_power = 8'd7;
        @(negedge clk);
        calc_damage = 1'b0;
        move_power  = 8'd3;
        @(negedge clk);
        ld_move = 1'b0;
        wait_valid("clamp_high");
        apply(1'b1);
        check("sat_ai_hp", ai_hp, 0);
        check("sat_ai_zero", ai_hp_zero, 1);
        apply(1'b1);
        check("double_apply_ai_hp", ai_hp, 0);
        check("double_apply_valid", dmg_valid, 0);

        // Target mismatch, then matching apply saturates the player
        load_move(8'd40);
        start(1'b0, 1'b0, 8'd95);
        @(negedge clk);
        calc_damage = 1'b0;
        wait_valid("mismatch");
        apply(1'b1);
        check("mismatch_p_hp", p_hp, 32);
        check("mismatch_valid", dmg_valid, 1);
        apply(1'b0);
        check("match_p_hp", p_hp, 0);
        check("match_p_zero", p_hp_zero, 1);

        // Reset aborts a calculation mid-MUL
        calc_damage    = 1'b1;
        active_trainer = 1'b0;
        target         = 1'b1;
        @(negedge clk);
        calc_damage = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_p_hp", p_hp, 100);
        check("abort_ai_hp", ai_hp, 100);
        check("abort_busy", busy, 0);
        check("abort_valid", dmg_valid, 0);
        check("abort_damage", damage, 0);
        repeat (15) @(negedge clk);
        check("abort_stays_idle", {busy, dmg_valid}, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
